// File: rtl/f_sweep_pkg.sv
// Shared types and constants for the f_realization truth-table sweeper.
package f_sweep_pkg;

  localparam int unsigned SWEEP_N  = 8;
  localparam int unsigned SWEEP_IW = 3;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned DIAG_CW  = 4;

  localparam logic [SWEEP_N-1:0] EXPECTED_DEF = 8'hED;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } sweep_state_t;

  // Number of set bits in a truth-table difference word (at most SWEEP_N).
  function automatic logic [DIAG_CW-1:0] popcnt8(input logic [SWEEP_N-1:0] v);
    logic [DIAG_CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(SWEEP_N); i++) begin
      c = c + DIAG_CW'(v[i]);
    end
    return c;
  endfunction

  // Index of the lowest set bit; 0 when the word is all zero.
  function automatic logic [SWEEP_IW-1:0] lowest_set(input logic [SWEEP_N-1:0] v);
    logic [SWEEP_IW-1:0] r;
    r = '0;
    for (int i = int'(SWEEP_N) - 1; i >= 0; i--) begin
      if (v[i]) r = SWEEP_IW'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/f_truth_sweeper_settle_cnt.sv
// Settle-time counter: cleared by the FSM on entry to a vector, counts while
// enabled, flags the last settle cycle combinationally.
module sweep_settle_cnt
  import f_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt;

  // Count register; clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_c = (cnt == limit - CNT_W'(1));

endmodule

// File: rtl/f_truth_sweeper.sv
// Truth-table sweeper: walks {w1,w2,w3} through all eight vectors, samples f
// after SETTLE cycles per vector and compares the word with EXPECTED.
// Optional diagnostics (err_cnt, fail_idx) are built when SWEEP_DIAG_EN is defined.
module f_truth_sweeper
  import f_sweep_pkg::*;
#(
  parameter logic [SWEEP_N-1:0] EXPECTED = EXPECTED_DEF,
  parameter int unsigned        SETTLE   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               f,
  output logic               w1,
  output logic               w2,
  output logic               w3,
  output logic               busy,
  output logic               done,
  output logic [SWEEP_N-1:0] truth,
`ifdef SWEEP_DIAG_EN
  output logic [DIAG_CW-1:0] err_cnt,
  output logic [SWEEP_IW-1:0] fail_idx,
`endif
  output logic               pass
);

  sweep_state_t        state_q, state_d;
  logic [SWEEP_IW-1:0] idx_q, idx_d;
  logic [SWEEP_IW-1:0] w_q, w_d;
  logic [SWEEP_N-1:0]  truth_q, truth_d;
  logic                pass_q, pass_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cnt_clr, cnt_en, cnt_tc;
`ifdef SWEEP_DIAG_EN
  logic [DIAG_CW-1:0]  err_q, err_d;
  logic [SWEEP_IW-1:0] fidx_q, fidx_d;
`endif

  sweep_settle_cnt u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (CNT_W'(SETTLE)),
    .tc_c  (cnt_tc)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      w_q     <= '0;
      truth_q <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SWEEP_DIAG_EN
      err_q   <= '0;
      fidx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      truth_q <= truth_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SWEEP_DIAG_EN
      err_q   <= err_d;
      fidx_q  <= fidx_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_d     = w_q;
    truth_d = truth_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`ifdef SWEEP_DIAG_EN
    err_d   = err_q;
    fidx_d  = fidx_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        w_d    = '0;
        if (start) begin
          state_d = ST_SETTLE;
          idx_d   = '0;
          truth_d = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_clr = 1'b1;
`ifdef SWEEP_DIAG_EN
          err_d   = '0;
          fidx_d  = '0;
`endif
        end
      end
      ST_SETTLE: begin
        w_d = idx_q;
        if (cnt_tc) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_CAPTURE: begin
        truth_d[idx_q] = f;
        if (idx_q == SWEEP_IW'(SWEEP_N - 1)) begin
          state_d = ST_DONE;
          pass_d  = (truth_d == EXPECTED);
          done_d  = 1'b1;
          w_d     = '0;
`ifdef SWEEP_DIAG_EN
          err_d   = popcnt8(truth_d ^ EXPECTED);
          fidx_d  = lowest_set(truth_d ^ EXPECTED);
`endif
        end else begin
          state_d = ST_SETTLE;
          idx_d   = idx_q + SWEEP_IW'(1);
          w_d     = idx_q + SWEEP_IW'(1);
          cnt_clr = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        w_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w1    = w_q[2];
  assign w2    = w_q[1];
  assign w3    = w_q[0];
  assign busy  = busy_q;
  assign done  = done_q;
  assign truth = truth_q;
  assign pass  = pass_q;
`ifdef SWEEP_DIAG_EN
  assign err_cnt  = err_q;
  assign fail_idx = fidx_q;
`endif

endmodule

// File: tb/tb_f_truth_sweeper.sv
// Bench for f_truth_sweeper with a behavioural f_realization (table 8'hED).
module tb_f_truth_sweeper;
  import f_sweep_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  logic       f_stub = 1'b0;
  logic [7:0] ftab = 8'hED;

  logic       w1, w2, w3, busy, done, pass, f;
  logic [7:0] truth;
  logic       x1, x2, x3, busy3, done3, pass3, f3;
  logic [7:0] truth3;
`ifdef SWEEP_DIAG_EN
  logic [3:0] err_cnt, err_cnt3;
  logic [2:0] fail_idx, fail_idx3;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] q_truth[$];
  logic       q_pass[$];

  always #5 clk = ~clk;

  // Function block under test: combinational from w1..w3, or stuck at 0.
  assign f  = f_stub ? 1'b0 : ftab[{w1, w2, w3}];
  assign f3 = ftab[{x1, x2, x3}];

  f_truth_sweeper #(.EXPECTED(8'hED), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f(f),
    .w1(w1), .w2(w2), .w3(w3), .busy(busy), .done(done), .truth(truth),
`ifdef SWEEP_DIAG_EN
    .err_cnt(err_cnt), .fail_idx(fail_idx),
`endif
    .pass(pass)
  );

  f_truth_sweeper #(.EXPECTED(8'hED), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .f(f3),
    .w1(x1), .w2(x2), .w3(x3), .busy(busy3), .done(done3), .truth(truth3),
`ifdef SWEEP_DIAG_EN
    .err_cnt(err_cnt3), .fail_idx(fail_idx3),
`endif
    .pass(pass3)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_w"},     8'({w1, w2, w3}), 8'd0);
    check({tag, "_busy"},  8'(busy),  8'd0);
    check({tag, "_done"},  8'(done),  8'd0);
    check({tag, "_truth"}, truth,     8'd0);
    check({tag, "_pass"},  8'(pass),  8'd0);
    check({tag, "_state"}, 8'(dut.state_q), 8'(ST_IDLE));
  endtask

  // Pop the scoreboard entry for a finished sweep and compare.
  task automatic score(input string tag);
    logic [7:0] et;
    logic       ep;
    check({tag, "_sb_nonempty"}, 8'(q_truth.size() > 0), 8'd1);
    if (q_truth.size() > 0) begin
      et = q_truth.pop_front();
      ep = q_pass.pop_front();
      check({tag, "_truth"}, truth, et);
      check({tag, "_pass"},  8'(pass), 8'(ep));
    end
  endtask

  // One sweep on the SETTLE=1 instance; optional start pulses at edges 3 and 10.
  task automatic sweep(input string tag, input logic [7:0] exp_t, input bit glitch);
    int n;
    bit seen;
    q_truth.push_back(exp_t);
    q_pass.push_back(exp_t == 8'hED);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_e0"}, 8'(busy), 8'd1);
    check({tag, "_w_e0"}, 8'({w1, w2, w3}), 8'd0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      start = glitch && (n == 2 || n == 9);
      if (done) seen = 1'b1;
      else if (n % 4 == 2) check({tag, "_w_vec"}, 8'({w1, w2, w3}), 8'(n / 2));
    end
    start = 1'b0;
    check({tag, "_done_edge"}, 8'(n), 8'd16);
    if (seen) begin
      score(tag);
      check({tag, "_busy_done"}, 8'(busy), 8'd1);
      check({tag, "_w_done"}, 8'({w1, w2, w3}), 8'd0);
      @(posedge clk); #1;
      check({tag, "_done_fall"}, 8'(done), 8'd0);
      check({tag, "_busy_fall"}, 8'(busy), 8'd0);
      check({tag, "_pass_held"}, 8'(pass), 8'(exp_t == 8'hED));
    end
  endtask

  initial begin
    int n;
    int dcount;
    bit seen;

    // Reset state.
    #12;
    check_zero("reset");
    check("reset3_busy", 8'(busy3), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Real function block: expect 8'hED and pass.
    sweep("real", 8'hED, 1'b0);
`ifdef SWEEP_DIAG_EN
    check("real_err_cnt", 8'(err_cnt), 8'd0);
    check("real_fail_idx", 8'(fail_idx), 8'd0);
`endif

    // Stuck-at-0 stub: expect 0 and fail.
    f_stub = 1'b1;
    sweep("stub", 8'h00, 1'b0);
`ifdef SWEEP_DIAG_EN
    check("stub_err_cnt", 8'(err_cnt), 8'd6);
    check("stub_fail_idx", 8'(fail_idx), 8'd0);
`endif
    f_stub = 1'b0;

    // Reset mid-sweep at edge 7, then a clean sweep.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    sweep("after_rst", 8'hED, 1'b0);

    // Start pulses while busy are ignored.
    sweep("glitch", 8'hED, 1'b1);
    dcount = 0;
    repeat (24) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    check("glitch_no_requeue", 8'(dcount), 8'd0);

    // Start held high: back-to-back sweeps.
    q_truth.push_back(8'hED); q_pass.push_back(1'b1);
    q_truth.push_back(8'hED); q_pass.push_back(1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      n = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
        @(posedge clk); #1;
        n++;
        if (done) seen = 1'b1;
      end
      check("b2b_done_edge", 8'(n), 8'd16);
      score("b2b");
      @(posedge clk); #1;
      check("b2b_gap_busy", 8'(busy), 8'd0);
      @(posedge clk); #1;
      if (s == 0) check("b2b_rebusy", 8'(busy), 8'd1);
      else start = 1'b0;
    end
    check("b2b_sb_drained", 8'(q_truth.size()), 8'd0);

    // SETTLE=3 instance: vectors every 4 cycles, done after edge 32.
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done3) seen = 1'b1;
      else if (n % 4 == 1) check("s3_w_vec", 8'({x1, x2, x3}), 8'(n / 4));
    end
    check("s3_done_edge", 8'(n), 8'd32);
    check("s3_truth", truth3, 8'hED);
    check("s3_pass", 8'(pass3), 8'd1);
    @(posedge clk); #1;
    check("s3_done_fall", 8'(done3), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/f_truth_sweeper.md
# f_truth_sweeper

Sequential truth-table sweeper for the three-input `f_realization` function block. It drives `w1`/`w2`/`w3` through all eight combinations and waits a programmable settle time per vector. It then samples `f` and assembles the results into an 8-bit truth-table word. It compares that word against an expected constant and reports pass/fail through a start/done handshake. It sits on both sides of `f_realization`: upstream as stimulus source, downstream as result consumer.

## Interface
- `EXPECTED`, default 8'hED: golden truth table; bit i = f for {w1,w2,w3} = i.
- `SETTLE`, default 1: cycles inputs are held before `f` is sampled; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: sweep request, sampled in IDLE only.
- `f` in 1: output of the function block under test.
- `w1`, `w2`, `w3` out 1 each: stimulus, {w1,w2,w3} = current vector index.
- `busy` out 1: high from the cycle after `start` is accepted until DONE exits.
- `done` out 1: one-cycle pulse at sweep end.
- `truth` out 8: captured truth table, held until the next accepted `start`.
- `pass` out 1: `truth == EXPECTED`, valid from `done` and held.

## Operation
- Reset values are all zero:
  - outputs `w1`/`w2`/`w3`, `busy`, `done`, `truth`, `pass`;
  - state = IDLE, index = 0, settle count = 0.
- FSM states: IDLE, SETTLE, CAPTURE, DONE.
- **IDLE**
  - On `start` = 1, go to SETTLE.
  - Set index = 0, clear `truth` and `pass`.
- **SETTLE**
  - Drive the index on `w1..w3`; count cycles.
  - After `SETTLE` cycles, go to CAPTURE.
- **CAPTURE**
  - Write `truth[index]` = `f`.
  - If index = 7, go to DONE and register `pass` from the complete word, including the bit just sampled.
  - Otherwise increment the index (3-bit, no wrap used), clear the count, and return to SETTLE.
- **DONE**
  - `done` = 1 for this cycle only, then go to IDLE.
  - `w1..w3` return to 0.
- `start` while busy or in DONE is ignored and not queued.
- `start` held high continuously restarts a sweep on every IDLE visit (back-to-back sweeps).
- `rst_n` low mid-sweep forces IDLE immediately, with all outputs at reset values. A partial `truth` is discarded.
- `f` is assumed combinational from `w1..w3`. Sampling is only in CAPTURE.

## Timing
- `start` is sampled high at edge 0; the first vector is driven after edge 0.
- Each vector occupies `SETTLE`+1 cycles, so the last capture is at edge 8·(`SETTLE`+1).
- `done` and `pass` become visible after edge 8·(`SETTLE`+1). `done` falls after the next edge.
- With the default `SETTLE` = 1, `done` is high in the cycle after edge 16.
- `busy` is high after edge 0 through the `done` cycle.
- Earliest next accept: the edge after `done` falls, i.e. edge 8·(`SETTLE`+1)+2.

## Configuration
- `SWEEP_DIAG_EN` defined adds outputs `err_cnt` (out 4) and `fail_idx` (out 3):
  - `err_cnt` = number of mismatching bits versus `EXPECTED`, saturating at 8.
  - `fail_idx` = lowest mismatching index; 0 when `pass` = 1.
  - Both are registered with `pass`, cleared on reset and on `start` accept.
- `SWEEP_DIAG_EN` undefined: the ports and logic are absent. Core behaviour is identical.

## Structure
- Shared package `f_sweep_pkg` holds:
  - the state enum (IDLE, SETTLE, CAPTURE, DONE);
  - `SWEEP_N` = 8;
  - default `EXPECTED` constant 8'hED;
  - settle-count width 4.
- One sub-module, `sweep_settle_cnt`: a 4-bit load/count/terminal-count counter driven by the FSM.
- The bench instantiates `f_truth_sweeper` connected to the existing `f_realization`.

## Test plan
- Reset, then `start` pulse with the real `f_realization` → `truth` = 8'hED, `pass` = 1, `done` after edge 16 for exactly one cycle.
- Force `f` = 0 throughout (stub) → `truth` = 8'h00, `pass` = 0. With `SWEEP_DIAG_EN`: `err_cnt` = 6, `fail_idx` = 0.
- Assert `rst_n` low at edge 7 mid-sweep → outputs 0 and state IDLE in the same cycle. A new `start` then completes with `truth` = 8'hED.
- Pulse `start` again at edges 3 and 10 while busy → no effect; a single `done`, still after edge 16.
- `SETTLE` = 3 build → stimulus changes every 4 cycles, `done` after edge 32, `pass` = 1.
- Hold `start` high for two sweeps → second `busy` begins after the edge following the `done` cycle; both report `pass` = 1.
